clock_hms: RTL and testbench

Parametrised hours:minutes:seconds timekeeping core, the successor to the two-stage minutes:seconds counter chain in the clock top. It generates its own 1 Hz enable from `CLK` and keeps seconds, minutes and hours with correct carries. It supports run/stop, per-field setting, and a compile-time 12 h or 24 h display mode. Outputs are registered BCD digits that drive the existing seg7 decoders directly. Key inputs are single-cycle pulses from the existing debouncer.

---
 rtl/clock_hms.sv | 173 +++++++++++++++++
 tb/tb_clock_hms.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_hms.sv
// Hours:minutes:seconds timekeeping core with 1 Hz prescaler, set pulses and registered BCD digits.
// Optional alarm logic is compiled in with `define CLOCK_ALARM_EN.
module clock_hms #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned HOUR_24 = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       run_tgl,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       inc_hr,
`ifdef CLOCK_ALARM_EN
    input  logic       al_set,
    input  logic       al_ack,
    input  logic       al_on,
    output logic       alarm,
`endif
    output logic [3:0] sec_l,
    output logic [3:0] sec_u,
    output logic [3:0] min_l,
    output logic [3:0] min_u,
    output logic [3:0] hr_l,
    output logic [3:0] hr_u,
    output logic       pm,
    output logic       tick,
    output logic       running
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] pcnt;
    logic [5:0]    s, m;
    logic [4:0]    h;
    logic [5:0]    s_nx, m_nx;
    logic [4:0]    h_nx;
    logic          en1hz, adv, c_s, c_m;

    assign en1hz = (pcnt == PMAX);
    assign adv   = running & en1hz;

    // A set pulse on a field wins over the advance/carry into it and swallows its carry out.
    always_comb begin
        s_nx = s;
        m_nx = m;
        h_nx = h;
        c_s  = 1'b0;
        c_m  = 1'b0;
        if (inc_sec) begin
            s_nx = (s == 6'd59) ? 6'd0 : s + 6'd1;
        end else if (adv) begin
            s_nx = (s == 6'd59) ? 6'd0 : s + 6'd1;
            c_s  = (s == 6'd59);
        end
        if (inc_min) begin
            m_nx = (m == 6'd59) ? 6'd0 : m + 6'd1;
        end else if (c_s) begin
            m_nx = (m == 6'd59) ? 6'd0 : m + 6'd1;
            c_m  = (m == 6'd59);
        end
        if (inc_hr || c_m) begin
            h_nx = (h == 5'd23) ? 5'd0 : h + 5'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt    <= '0;
            s       <= '0;
            m       <= '0;
            h       <= '0;
            tick    <= 1'b0;
            running <= 1'b1;
        end else if (clr) begin
            pcnt <= '0;
            s    <= '0;
            m    <= '0;
            h    <= '0;
            tick <= 1'b0;
        end else begin
            pcnt    <= en1hz ? '0 : pcnt + 1'b1;
            s       <= s_nx;
            m       <= m_nx;
            h       <= h_nx;
            tick    <= en1hz;
            running <= running ^ run_tgl;
        end
    end

    logic [4:0] hd;
    logic       pm_nx;

    always_comb begin
        hd    = h;
        pm_nx = 1'b0;
        if (HOUR_24 == 0) begin
            if (h == 5'd0) begin
                hd = 5'd12;
            end else if (h < 5'd12) begin
                hd = h;
            end else if (h == 5'd12) begin
                hd    = 5'd12;
                pm_nx = 1'b1;
            end else begin
                hd    = h - 5'd12;
                pm_nx = 1'b1;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Display registers add one cycle after the counter update.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sec_l <= 4'd0;
            sec_u <= 4'd0;
            min_l <= 4'd0;
            min_u <= 4'd0;
            hr_l  <= (HOUR_24 != 0) ? 4'd0 : 4'd2;
            hr_u  <= (HOUR_24 != 0) ? 4'd0 : 4'd1;
            pm    <= 1'b0;
        end else begin
            {sec_u, sec_l} <= to_bcd(s);
            {min_u, min_l} <= to_bcd(m);
            {hr_u, hr_l}   <= to_bcd({1'b0, hd});
            pm             <= pm_nx;
        end
    end

`ifdef CLOCK_ALARM_EN
    logic [4:0] ah;
    logic [5:0] am;
    logic [5:0] acnt;
    logic       hit;

    // Only a pure clock advance into hh:mm:00 may fire; edits never do.
    assign hit = adv && !inc_sec && !inc_min && !inc_hr && (s == 6'd59) &&
                 (m_nx == am) && (h_nx == ah) && al_on;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ah    <= '0;
            am    <= '0;
            acnt  <= '0;
            alarm <= 1'b0;
        end else if (clr) begin
            acnt  <= '0;
            alarm <= 1'b0;
        end else begin
            if (al_set) begin
                ah <= h;
                am <= m;
            end
            if (alarm) begin
                if (al_ack || !al_on || (en1hz && acnt == 6'd59)) begin
                    alarm <= 1'b0;
                end else if (en1hz) begin
                    acnt <= acnt + 6'd1;
                end
            end else if (hit) begin
                alarm <= 1'b1;
                acnt  <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clock_hms.sv
// Scoreboard bench for clock_hms: a 24 h and a 12 h instance share random and directed
// stimulus; a seconds-of-day reference model predicts digits, tick and run state.
module tb_clock_hms;

    localparam int HZ = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic clr = 1'b0, run_tgl = 1'b0, inc_sec = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
    wire [23:0] d24, d12;
    wire pm24, pm12, tk24, tk12, rn24, rn12;
`ifdef CLOCK_ALARM_EN
    logic al_set = 1'b0, al_ack = 1'b0, al_on = 1'b0;
    wire  alarm24, alarm12;
`endif

    always #5 CLK = ~CLK;

    clock_hms #(.CLK_HZ(HZ), .HOUR_24(1)) u24 (
        .CLK(CLK), .RST(RST), .clr(clr), .run_tgl(run_tgl),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef CLOCK_ALARM_EN
        .al_set(al_set), .al_ack(al_ack), .al_on(al_on), .alarm(alarm24),
`endif
        .sec_l(d24[3:0]), .sec_u(d24[7:4]), .min_l(d24[11:8]), .min_u(d24[15:12]),
        .hr_l(d24[19:16]), .hr_u(d24[23:20]), .pm(pm24), .tick(tk24), .running(rn24)
    );

    clock_hms #(.CLK_HZ(HZ), .HOUR_24(0)) u12 (
        .CLK(CLK), .RST(RST), .clr(clr), .run_tgl(run_tgl),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef CLOCK_ALARM_EN
        .al_set(al_set), .al_ack(al_ack), .al_on(al_on), .alarm(alarm12),
`endif
        .sec_l(d12[3:0]), .sec_u(d12[7:4]), .min_l(d12[11:8]), .min_u(d12[15:12]),
        .hr_l(d12[19:16]), .hr_u(d12[23:20]), .pm(pm12), .tick(tk12), .running(rn12)
    );

    typedef struct { int at; bit tk; bit rn; } st_t;
    typedef struct { int at; int tt; } dp_t;
    st_t st_q[$];
    dp_t dp_q[$];

    int  errors = 0, checks = 0, edge_cnt = 0;
    // Reference model: seconds of day, prescaler phase and run state.
    int  t = 0, pc = 0;
    bit  run = 1'b1;

    function automatic logic [23:0] digits(input int tt, input bit twelve);
        int h, m, s, hd;
        h  = tt / 3600;
        m  = (tt / 60) % 60;
        s  = tt % 60;
        hd = twelve ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin : monitor
        st_t e;
        dp_t d;
        logic [23:0] x24, x12;
        bit xpm;
        forever begin
            @(posedge CLK);
            edge_cnt++;
            #1;
            while (st_q.size() > 0 && st_q[0].at <= edge_cnt) begin
                e = st_q.pop_front();
                checks += 2;
                if (tk24 !== e.tk || rn24 !== e.rn) begin
                    errors++;
                    $display("FAIL state24 @edge %0d: tick/running got %b%b want %b%b",
                             edge_cnt, tk24, rn24, e.tk, e.rn);
                end
                if (tk12 !== e.tk || rn12 !== e.rn) begin
                    errors++;
                    $display("FAIL state12 @edge %0d: tick/running got %b%b want %b%b",
                             edge_cnt, tk12, rn12, e.tk, e.rn);
                end
            end
            while (dp_q.size() > 0 && dp_q[0].at <= edge_cnt) begin
                d   = dp_q.pop_front();
                x24 = digits(d.tt, 1'b0);
                x12 = digits(d.tt, 1'b1);
                xpm = (d.tt / 3600) >= 12;
                checks += 2;
                if (d24 !== x24 || pm24 !== 1'b0) begin
                    errors++;
                    $display("FAIL disp24 @edge %0d: got %h pm%b want %h pm0",
                             edge_cnt, d24, pm24, x24);
                end
                if (d12 !== x12 || pm12 !== xpm) begin
                    errors++;
                    $display("FAIL disp12 @edge %0d: got %h pm%b want %h pm%b",
                             edge_cnt, d12, pm12, x12, xpm);
                end
            end
        end
    end

    // One clock cycle of stimulus; inputs applied at a falling edge.
    task automatic step(input bit c, input bit tg, input bit is, input bit im, input bit ih);
        int s, m, h, ta, ns, nm, nh;
        bit en, tk;
        clr = c; run_tgl = tg; inc_sec = is; inc_min = im; inc_hr = ih;
        en = (pc == HZ - 1);
        tk = 1'b0;
        if (c) begin
            t  = 0;
            pc = 0;
        end else begin
            s  = t % 60;
            m  = (t / 60) % 60;
            h  = t / 3600;
            ta = (run && en) ? (t + 1) % 86400 : t;
            ns = is ? (s + 1) % 60 : ta % 60;
            nm = im ? (m + 1) % 60 : (is ? m : (ta / 60) % 60);
            nh = ih ? (h + 1) % 24 : ((is || im) ? h : ta / 3600);
            t  = nh * 3600 + nm * 60 + ns;
            pc = en ? 0 : pc + 1;
            tk = en;
            run = run ^ tg;
        end
        st_q.push_back('{at: edge_cnt + 1, tk: tk, rn: run});
        dp_q.push_back('{at: edge_cnt + 2, tt: t});
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_run(input bit r);
        if (run != r) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_time(input int hh, input int mm, input int ss);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_run(1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, i < ss, i < mm, i < hh);
    endtask

    // Idle until the next cycle carries an advance from second ws (and minute wm if >= 0).
    task automatic run_until(input int ws, input int wm);
        int n = 0;
        while (!(pc == HZ - 1 && run && t % 60 == ws && (wm < 0 || (t / 60) % 60 == wm))
               && n < 2000) begin
            idle(1);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL run_until timeout: got %0d cycles want < 2000", n);
        end
    endtask

    task automatic check_reset(input string tag);
        checks += 4;
        if (d24 !== 24'h000000 || pm24 !== 1'b0) begin
            errors++;
            $display("FAIL %s disp24: got %h pm%b want 000000 pm0", tag, d24, pm24);
        end
        if (d12 !== 24'h120000 || pm12 !== 1'b0) begin
            errors++;
            $display("FAIL %s disp12: got %h pm%b want 120000 pm0", tag, d12, pm12);
        end
        if (tk24 !== 1'b0 || tk12 !== 1'b0) begin
            errors++;
            $display("FAIL %s tick: got %b%b want 00", tag, tk24, tk12);
        end
        if (rn24 !== 1'b1 || rn12 !== 1'b1) begin
            errors++;
            $display("FAIL %s running: got %b%b want 11", tag, rn24, rn12);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        #1 RST = 1'b0;
        #2 check_reset("por");
        @(negedge CLK);
        RST = 1'b1;
        idle(12);                                  // prescaler: ticks at 4, 8, 12
        set_time(23, 59, 59);                      // rollover 23:59:59 / 11:59:59 PM
        set_run(1'b1);
        run_until(59, 59);
        idle(6);
        run_until(59, -1);                         // inc_sec collides with the wrap
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        set_time(0, 30, 40);                       // inc_min collides with the carry
        set_run(1'b1);
        run_until(59, 30);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        set_run(1'b0);                             // stopped: ticks continue, sets apply
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0);
        set_run(1'b1);
        idle(20);
        set_time(5, 43, 21);                       // clear
        set_run(1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        for (int i = 0; i < 800; i++)
            step(($urandom % 128) == 0, ($urandom % 32) == 0, ($urandom % 12) == 0,
                 ($urandom % 12) == 0, ($urandom % 12) == 0);
        set_run(1'b1);                             // reset just before a carry edge
        run_until(59, -1);
        RST = 1'b0;
        st_q.delete();
        dp_q.delete();
        #1 check_reset("midrst");
        @(negedge CLK);
        @(negedge CLK);
        t = 0; pc = 0; run = 1'b1;
        RST = 1'b1;
        idle(20);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
